// File: rtl/psram_arbiter_if.sv
// Request/response bundle between the CPU port, the video fetch port and the psram controller.
// The arbiter uses the slave modport; requesters and the psram model drive through master.
interface psram_arbiter_if;
  logic        i_cpu_req;
  logic        i_cpu_we;
  logic [23:0] i_cpu_addr;
  logic [15:0] i_cpu_wdata;
  logic        o_cpu_gnt;
  logic        o_cpu_done;
  logic        o_cpu_err;
  logic [15:0] o_cpu_rdata;

  logic        i_vid_req;
  logic        i_vid_we;
  logic [23:0] i_vid_addr;
  logic [15:0] i_vid_wdata;
  logic        o_vid_gnt;
  logic        o_vid_done;
  logic        o_vid_err;
  logic [15:0] o_vid_rdata;

  logic        o_psram_stb;
  logic        o_psram_we;
  logic [23:0] o_psram_addr;
  logic [15:0] o_psram_din;
  logic        i_psram_busy;
  logic        i_psram_done;
  logic [15:0] i_psram_dout;
  logic        o_owner;

  modport slave (
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    output o_cpu_gnt, o_cpu_done, o_cpu_err, o_cpu_rdata,
    input  i_vid_req, i_vid_we, i_vid_addr, i_vid_wdata,
    output o_vid_gnt, o_vid_done, o_vid_err, o_vid_rdata,
    output o_psram_stb, o_psram_we, o_psram_addr, o_psram_din,
    input  i_psram_busy, i_psram_done, i_psram_dout,
    output o_owner
  );

  modport master (
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    input  o_cpu_gnt, o_cpu_done, o_cpu_err, o_cpu_rdata,
    output i_vid_req, i_vid_we, i_vid_addr, i_vid_wdata,
    input  o_vid_gnt, o_vid_done, o_vid_err, o_vid_rdata,
    input  o_psram_stb, o_psram_we, o_psram_addr, o_psram_din,
    output i_psram_busy, i_psram_done, i_psram_dout,
    input  o_owner
  );
endinterface

// File: rtl/psram_arbiter.sv
// Two-port (CPU / video) arbiter in front of the psram controller, one stb/done transaction at a time.
// Default: video priority with a bounded run; define PSRAM_ARB_RR_EN for round-robin ties.
module psram_arbiter #(
  parameter int VID_MAX_RUN = 4,
  parameter int TIMEOUT     = 255
) (
  input logic            i_clk,
  input logic            i_rstn,
  psram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state_q;
  logic [7:0]  tmo_q;
  logic        owner_q;
  logic        stb_q;
  logic        we_q;
  logic [23:0] addr_q;
  logic [15:0] din_q;
  logic        cpu_gnt_q, vid_gnt_q;
  logic        cpu_done_q, vid_done_q;
  logic        cpu_err_q, vid_err_q;
  logic [15:0] cpu_rdata_q, vid_rdata_q;

  logic        arb_d;
  logic        vid_win_d;

  assign arb_d = (state_q == IDLE) && (bus.i_cpu_req || bus.i_vid_req) && !bus.i_psram_busy;

`ifdef PSRAM_ARB_RR_EN
  // owner_q resets to CPU, so the first tie after reset goes to video.
  always_comb begin
    vid_win_d = bus.i_vid_req;
    if (bus.i_cpu_req && bus.i_vid_req) vid_win_d = ~owner_q;
  end
`else
  localparam int RUN_W = (VID_MAX_RUN < 1) ? 1 : $clog2(VID_MAX_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(VID_MAX_RUN);

  logic [RUN_W-1:0] run_q, run_d;

  function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
    if (v >= RUN_MAX) return v;
    return v + RUN_W'(1);
  endfunction

  // Video wins unless it has already taken VID_MAX_RUN grants past a waiting CPU.
  always_comb begin
    vid_win_d = bus.i_vid_req && !(bus.i_cpu_req && (run_q == RUN_MAX));
    run_d     = '0;
    if (bus.i_cpu_req && vid_win_d) run_d = sat_inc(run_q);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      run_q <= '0;
    end else if (arb_d) begin
      run_q <= run_d;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      owner_q     <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      cpu_gnt_q   <= 1'b0;
      vid_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      vid_done_q  <= 1'b0;
      cpu_err_q   <= 1'b0;
      vid_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_d) begin
            owner_q   <= vid_win_d;
            we_q      <= vid_win_d ? bus.i_vid_we    : bus.i_cpu_we;
            addr_q    <= vid_win_d ? bus.i_vid_addr  : bus.i_cpu_addr;
            din_q     <= vid_win_d ? bus.i_vid_wdata : bus.i_cpu_wdata;
            stb_q     <= 1'b1;
            cpu_gnt_q <= ~vid_win_d;
            vid_gnt_q <= vid_win_d;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          stb_q     <= 1'b0;
          cpu_gnt_q <= 1'b0;
          vid_gnt_q <= 1'b0;
          tmo_q     <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (bus.i_psram_done) begin
            if (!we_q) begin
              if (owner_q) vid_rdata_q <= bus.i_psram_dout;
              else         cpu_rdata_q <= bus.i_psram_dout;
            end
            cpu_done_q <= ~owner_q;
            vid_done_q <= owner_q;
            state_q    <= DONE;
          end else if (tmo_q == 8'(TIMEOUT - 1)) begin
            // Abort: report completion with err so the requester never hangs.
            cpu_done_q <= ~owner_q;
            vid_done_q <= owner_q;
            cpu_err_q  <= ~owner_q;
            vid_err_q  <= owner_q;
            state_q    <= DONE;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        DONE: begin
          cpu_done_q <= 1'b0;
          vid_done_q <= 1'b0;
          cpu_err_q  <= 1'b0;
          vid_err_q  <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_cpu_gnt    = cpu_gnt_q;
  assign bus.o_cpu_done   = cpu_done_q;
  assign bus.o_cpu_err    = cpu_err_q;
  assign bus.o_cpu_rdata  = cpu_rdata_q;
  assign bus.o_vid_gnt    = vid_gnt_q;
  assign bus.o_vid_done   = vid_done_q;
  assign bus.o_vid_err    = vid_err_q;
  assign bus.o_vid_rdata  = vid_rdata_q;
  assign bus.o_psram_stb  = stb_q;
  assign bus.o_psram_we   = we_q;
  assign bus.o_psram_addr = addr_q;
  assign bus.o_psram_din  = din_q;
  assign bus.o_owner      = owner_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter: reset, CPU read, arbitration order, busy hold-off,
// timeout abort, video write and mid-transaction reset.
module tb_psram_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  psram_arbiter_if bus ();

  psram_arbiter #(.VID_MAX_RUN(4), .TIMEOUT(255)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.o_cpu_gnt, bus.o_vid_gnt, bus.o_cpu_done, bus.o_vid_done, bus.o_cpu_err, bus.o_vid_err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000",
        {bus.o_cpu_gnt, bus.o_vid_gnt, bus.o_cpu_done, bus.o_vid_done, bus.o_cpu_err, bus.o_vid_err});
    end
    checks++;
    if ({bus.o_psram_stb, bus.o_psram_we, bus.o_owner} !== 3'b0) begin
      errors++; $display("FAIL reset_stb_we_owner got %b want 000", {bus.o_psram_stb, bus.o_psram_we, bus.o_owner});
    end
    checks++;
    if ({bus.o_psram_addr, bus.o_psram_din, bus.o_cpu_rdata, bus.o_vid_rdata} !== 72'h0) begin
      errors++; $display("FAIL reset_data got %h want 0",
        {bus.o_psram_addr, bus.o_psram_din, bus.o_cpu_rdata, bus.o_vid_rdata});
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_cpu_read;
    bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 24'h000123;
    tick();
    checks++;
    if ({bus.o_cpu_gnt, bus.o_vid_gnt, bus.o_psram_stb} !== 3'b101) begin
      errors++; $display("FAIL cpu_read_gnt got %b want 101", {bus.o_cpu_gnt, bus.o_vid_gnt, bus.o_psram_stb});
    end
    checks++;
    if ({bus.o_psram_addr, bus.o_psram_we, bus.o_owner} !== {24'h000123, 1'b0, 1'b0}) begin
      errors++; $display("FAIL cpu_read_cmd got addr %h we %b owner %b want 000123 0 0",
        bus.o_psram_addr, bus.o_psram_we, bus.o_owner);
    end
    bus.i_cpu_req = 1'b0;
    tick();
    checks++;
    if ({bus.o_cpu_gnt, bus.o_psram_stb, bus.o_cpu_done} !== 3'b000) begin
      errors++; $display("FAIL cpu_read_wait got %b want 000", {bus.o_cpu_gnt, bus.o_psram_stb, bus.o_cpu_done});
    end
    bus.i_psram_done = 1'b1; bus.i_psram_dout = 16'hBEEF;
    tick();
    bus.i_psram_done = 1'b0;
    checks++;
    if ({bus.o_cpu_done, bus.o_cpu_err, bus.o_vid_done} !== 3'b100 || bus.o_cpu_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL cpu_read_done got done/err/vdone %b rdata %h want 100 BEEF",
        {bus.o_cpu_done, bus.o_cpu_err, bus.o_vid_done}, bus.o_cpu_rdata);
    end
    tick();
    checks++;
    if (bus.o_cpu_done !== 1'b0 || bus.o_cpu_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL cpu_read_hold got done %b rdata %h want 0 BEEF", bus.o_cpu_done, bus.o_cpu_rdata);
    end
  endtask

  task automatic test_priority;
    bit exp_v [10];
    int n;
`ifdef PSRAM_ARB_RR_EN
    exp_v = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`else
    exp_v = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif
    bus.i_cpu_we = 1'b0; bus.i_vid_we = 1'b0;
    bus.i_cpu_req = 1'b1; bus.i_vid_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (!(bus.o_cpu_gnt || bus.o_vid_gnt) && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (n == 20) begin
        errors++; $display("FAIL prio_gnt_timeout grant %0d got none want a grant", i);
        bus.i_cpu_req = 1'b0; bus.i_vid_req = 1'b0;
        return;
      end
      if (bus.o_vid_gnt !== exp_v[i] || bus.o_cpu_gnt !== !exp_v[i]) begin
        errors++; $display("FAIL prio_order grant %0d got vid %b cpu %b want vid %b", i, bus.o_vid_gnt, bus.o_cpu_gnt, exp_v[i]);
      end
      if (i > 0) begin
        checks++;
        if (n != 2) begin
          errors++; $display("FAIL prio_b2b_gap grant %0d got %0d cycles want 2", i, n);
        end
      end
      tick();
      bus.i_psram_done = 1'b1; bus.i_psram_dout = 16'(256 + i);
      tick();
      bus.i_psram_done = 1'b0;
      checks++;
      if (exp_v[i] ? (bus.o_vid_done !== 1'b1 || bus.o_vid_rdata !== 16'(256 + i))
                   : (bus.o_cpu_done !== 1'b1 || bus.o_cpu_rdata !== 16'(256 + i))) begin
        errors++; $display("FAIL prio_done grant %0d got cdone %b vdone %b crd %h vrd %h want rdata %h", i,
          bus.o_cpu_done, bus.o_vid_done, bus.o_cpu_rdata, bus.o_vid_rdata, 16'(256 + i));
      end
      if (i == 9) begin
        bus.i_cpu_req = 1'b0; bus.i_vid_req = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_busy;
    bus.i_psram_busy = 1'b1;
    bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 24'h000200;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.o_psram_stb !== 1'b0 || bus.o_cpu_gnt !== 1'b0) begin
        errors++; $display("FAIL busy_hold cycle %0d got stb %b gnt %b want 0 0", i, bus.o_psram_stb, bus.o_cpu_gnt);
      end
    end
    bus.i_psram_busy = 1'b0;
    tick();
    checks++;
    if (bus.o_psram_stb !== 1'b1 || bus.o_cpu_gnt !== 1'b1) begin
      errors++; $display("FAIL busy_release got stb %b gnt %b want 1 1", bus.o_psram_stb, bus.o_cpu_gnt);
    end
    bus.i_cpu_req = 1'b0;
    tick();
    bus.i_psram_done = 1'b1; bus.i_psram_dout = 16'h3333;
    tick();
    bus.i_psram_done = 1'b0;
    checks++;
    if (bus.o_cpu_done !== 1'b1 || bus.o_cpu_rdata !== 16'h3333) begin
      errors++; $display("FAIL busy_done got done %b rdata %h want 1 3333", bus.o_cpu_done, bus.o_cpu_rdata);
    end
    tick();
  endtask

  task automatic test_timeout;
    int n;
    bus.i_vid_req = 1'b1; bus.i_vid_we = 1'b0; bus.i_vid_addr = 24'h000400;
    tick();
    checks++;
    if (bus.o_vid_gnt !== 1'b1) begin
      errors++; $display("FAIL tmo_gnt got %b want 1", bus.o_vid_gnt);
    end
    bus.i_vid_req = 1'b0;
    n = 0;
    while (!bus.o_vid_done && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n != 256) begin
      errors++; $display("FAIL tmo_latency got %0d cycles after gnt want 256", n);
    end
    checks++;
    if (bus.o_vid_err !== 1'b1 || bus.o_cpu_done !== 1'b0 || bus.o_vid_rdata !== 16'h0108) begin
      errors++; $display("FAIL tmo_err got err %b cdone %b vrd %h want 1 0 0108", bus.o_vid_err, bus.o_cpu_done, bus.o_vid_rdata);
    end
    tick();
    checks++;
    if (bus.o_vid_done !== 1'b0 || bus.o_vid_err !== 1'b0) begin
      errors++; $display("FAIL tmo_clear got done %b err %b want 0 0", bus.o_vid_done, bus.o_vid_err);
    end
    bus.i_psram_done = 1'b1; bus.i_psram_dout = 16'hDEAD;
    tick();
    bus.i_psram_done = 1'b0;
    checks++;
    if ({bus.o_vid_done, bus.o_cpu_done, bus.o_psram_stb} !== 3'b000 || bus.o_vid_rdata !== 16'h0108) begin
      errors++; $display("FAIL tmo_late_done got %b vrd %h want 000 0108",
        {bus.o_vid_done, bus.o_cpu_done, bus.o_psram_stb}, bus.o_vid_rdata);
    end
    bus.i_vid_req = 1'b1; bus.i_vid_addr = 24'h000005;
    tick();
    bus.i_vid_req = 1'b0;
    tick();
    bus.i_psram_done = 1'b1; bus.i_psram_dout = 16'h1234;
    tick();
    bus.i_psram_done = 1'b0;
    checks++;
    if (bus.o_vid_done !== 1'b1 || bus.o_vid_err !== 1'b0 || bus.o_vid_rdata !== 16'h1234) begin
      errors++; $display("FAIL tmo_recover got done %b err %b rdata %h want 1 0 1234", bus.o_vid_done, bus.o_vid_err, bus.o_vid_rdata);
    end
    tick();
  endtask

  task automatic test_video_write;
    bus.i_vid_req = 1'b1; bus.i_vid_we = 1'b1; bus.i_vid_addr = 24'h7FFFFF; bus.i_vid_wdata = 16'hABCD;
    tick();
    checks++;
    if ({bus.o_vid_gnt, bus.o_psram_stb, bus.o_psram_we, bus.o_owner} !== 4'b1111 ||
        bus.o_psram_addr !== 24'h7FFFFF || bus.o_psram_din !== 16'hABCD) begin
      errors++; $display("FAIL vwr_cmd got flags %b addr %h din %h want 1111 7FFFFF ABCD",
        {bus.o_vid_gnt, bus.o_psram_stb, bus.o_psram_we, bus.o_owner}, bus.o_psram_addr, bus.o_psram_din);
    end
    bus.i_vid_req = 1'b0; bus.i_vid_we = 1'b0; bus.i_vid_addr = 24'h000001; bus.i_vid_wdata = 16'h0000;
    tick();
    checks++;
    if (bus.o_psram_stb !== 1'b0 || bus.o_psram_addr !== 24'h7FFFFF || bus.o_psram_din !== 16'hABCD || bus.o_psram_we !== 1'b1) begin
      errors++; $display("FAIL vwr_latched got stb %b addr %h din %h we %b want 0 7FFFFF ABCD 1",
        bus.o_psram_stb, bus.o_psram_addr, bus.o_psram_din, bus.o_psram_we);
    end
    bus.i_psram_done = 1'b1; bus.i_psram_dout = 16'h5555;
    tick();
    bus.i_psram_done = 1'b0;
    checks++;
    if (bus.o_vid_done !== 1'b1 || bus.o_vid_rdata !== 16'h1234) begin
      errors++; $display("FAIL vwr_done got done %b rdata %h want 1 1234", bus.o_vid_done, bus.o_vid_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 24'h000042;
    tick();
    bus.i_cpu_req = 1'b0;
    tick();
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.o_owner, bus.o_psram_we, bus.o_psram_stb} !== 3'b000 || bus.o_psram_addr !== 24'h0 ||
        bus.o_psram_din !== 16'h0 || bus.o_cpu_rdata !== 16'h0 || bus.o_vid_rdata !== 16'h0) begin
      errors++; $display("FAIL rst_mid_zero got addr %h din %h crd %h vrd %h want all 0",
        bus.o_psram_addr, bus.o_psram_din, bus.o_cpu_rdata, bus.o_vid_rdata);
    end
    bus.i_psram_done = 1'b1; bus.i_psram_dout = 16'h7777;
    tick();
    bus.i_psram_done = 1'b0;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({bus.o_cpu_done, bus.o_vid_done, bus.o_cpu_err, bus.o_vid_err} !== 4'b0000) begin
        errors++; $display("FAIL rst_mid_no_done cycle %0d got %b want 0000", i,
          {bus.o_cpu_done, bus.o_vid_done, bus.o_cpu_err, bus.o_vid_err});
      end
    end
    bus.i_cpu_req = 1'b1; bus.i_cpu_addr = 24'h000043;
    tick();
    checks++;
    if (bus.o_cpu_gnt !== 1'b1 || bus.o_psram_addr !== 24'h000043) begin
      errors++; $display("FAIL rst_mid_fresh_gnt got gnt %b addr %h want 1 000043", bus.o_cpu_gnt, bus.o_psram_addr);
    end
    bus.i_cpu_req = 1'b0;
    tick();
    bus.i_psram_done = 1'b1; bus.i_psram_dout = 16'hCAFE;
    tick();
    bus.i_psram_done = 1'b0;
    checks++;
    if (bus.o_cpu_done !== 1'b1 || bus.o_cpu_err !== 1'b0 || bus.o_cpu_rdata !== 16'hCAFE) begin
      errors++; $display("FAIL rst_mid_fresh_done got done %b err %b rdata %h want 1 0 CAFE",
        bus.o_cpu_done, bus.o_cpu_err, bus.o_cpu_rdata);
    end
    tick();
  endtask

  initial begin
    bus.i_cpu_req = 1'b0; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = '0; bus.i_cpu_wdata = '0;
    bus.i_vid_req = 1'b0; bus.i_vid_we = 1'b0; bus.i_vid_addr = '0; bus.i_vid_wdata = '0;
    bus.i_psram_busy = 1'b0; bus.i_psram_done = 1'b0; bus.i_psram_dout = '0;
    test_reset();
    test_cpu_read();
    test_priority();
    test_busy();
    test_timeout();
    test_video_write();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
